// File: rtl/vector_pack_pkg.sv
// Shared definitions for the vector packer: fill-mode encodings and the
// width helper for the slice counter.
package vector_pack_pkg;

    localparam logic [1:0] FILL_ZERO = 2'b00;
    localparam logic [1:0] FILL_ONES = 2'b01;
    localparam logic [1:0] FILL_SIGN = 2'b10;
    localparam logic [1:0] FILL_X    = 2'b11;

    // Width needed to hold a slice count from 0 up to and including ratio.
    function automatic int cnt_w(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/vector_fill.sv
// Combinational fill generator for the vector packer. Given how many slices
// carry real data, it marks the remaining slices and supplies the fill pattern.
// Macro VECTOR_PACK_XFILL_EN: when defined, fill mode 11 drives X into unfilled
// bits; otherwise fill mode 11 is a plain zero fill.
module vector_fill
    import vector_pack_pkg::*;
#(
    parameter int IN_W      = 4,
    parameter int RATIO     = 4,
    parameter int MSB_FIRST = 1,
    localparam int OUT_W    = IN_W * RATIO,
    localparam int CW       = cnt_w(RATIO)
) (
    input  logic [CW-1:0]    count,
    input  logic [1:0]       fill_mode,
    input  logic             sign,
    output logic [OUT_W-1:0] fill_mask,
    output logic [OUT_W-1:0] fill_value
);

    typedef logic [CW-1:0] cnt_t;

    // Mark every slice at or beyond the number of real slices as unfilled.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        fill_mask = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (cnt_t'(k) >= count) begin
                if (MSB_FIRST != 0) begin
                    fill_mask[OUT_W-1-k*IN_W -: IN_W] = '1;
                end else begin
                    fill_mask[k*IN_W +: IN_W] = '1;
                end
            end
        end
    end

    // Select the pattern that lands in the unfilled bits.
    always_comb begin
        fill_value = '0;
        case (fill_mode)
            FILL_ONES: fill_value = '1;
            FILL_SIGN: fill_value = {OUT_W{sign}};
            FILL_X: begin
`ifdef VECTOR_PACK_XFILL_EN
                fill_value = 'x;
`else
                fill_value = '0;
`endif
            end
            default:   fill_value = '0;
        endcase
    end

endmodule

// File: rtl/vector_pack.sv
// Vector packer: collects IN_W-bit beats into one IN_W*RATIO-bit vector with
// valid/ready on both sides and fill of unused slices on early termination.
// Macro VECTOR_PACK_XFILL_EN: enables X fill for fill mode 11 (see vector_fill).
module vector_pack
    import vector_pack_pkg::*;
#(
    parameter int IN_W      = 4,
    parameter int RATIO     = 4,
    parameter int MSB_FIRST = 1,
    localparam int OUT_W    = IN_W * RATIO,
    localparam int CW       = cnt_w(RATIO)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    input  logic [1:0]       fill_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CW-1:0]    out_count
);

    typedef logic [CW-1:0] cnt_t;

    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] merged;
    logic [OUT_W-1:0] fill_mask;
    logic [OUT_W-1:0] fill_value;
    cnt_t             slot;
    cnt_t             slot_inc;
    logic             accept;
    logic             complete;

    // A beat may enter unless a finished vector is still waiting for its consumer.
    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || slot == cnt_t'(RATIO - 1));
    assign slot_inc = slot + cnt_t'(1);

    // Drop the incoming beat into the slice addressed by the current slot.
    always_comb begin
        merged = acc;
        for (int k = 0; k < RATIO; k++) begin
            if (slot == cnt_t'(k)) begin
                if (MSB_FIRST != 0) begin
                    merged[OUT_W-1-k*IN_W -: IN_W] = in_data;
                end else begin
                    merged[k*IN_W +: IN_W] = in_data;
                end
            end
        end
    end

    vector_fill #(
        .IN_W      (IN_W),
        .RATIO     (RATIO),
        .MSB_FIRST (MSB_FIRST)
    ) u_fill (
        .count      (slot_inc),
        .fill_mode  (fill_mode),
        .sign       (in_data[IN_W-1]),
        .fill_mask  (fill_mask),
        .fill_value (fill_value)
    );

    // Accumulate beats, publish the vector on completion, retire it on handshake.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register update tied to the same edge.
        if (!rst_n) begin
            acc       <= '0;
            slot      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (complete) begin
                out_data  <= (merged & ~fill_mask) | (fill_value & fill_mask);
                out_count <= slot_inc;
                out_valid <= 1'b1;
                acc       <= '0;
                slot      <= '0;
            end else if (accept) begin
                acc  <= merged;
                slot <= slot_inc;
            end
        end
    end

endmodule

// File: tb/tb_vector_pack.sv
// Self-checking bench for vector_pack: one MSB-first and one LSB-first instance
// share the same stimulus; a queue-based reference model predicts each vector.
module tb_vector_pack;

    localparam int IN_W  = 4;
    localparam int RATIO = 4;
    localparam int OUT_W = IN_W * RATIO;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic [1:0]       fill_mode;
    logic             out_ready;

    logic             in_ready_m, in_ready_l;
    logic             out_valid_m, out_valid_l;
    logic [OUT_W-1:0] out_data_m, out_data_l;
    logic [2:0]       out_count_m, out_count_l;

    int checks = 0;
    int errors = 0;
    bit rand_ready = 0;

    logic [OUT_W-1:0] exp_m[$];
    logic [OUT_W-1:0] exp_l[$];
    logic [2:0]       expc[$];

    vector_pack #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_data(in_data), .in_last(in_last), .fill_mode(fill_mode),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
        .out_count(out_count_m)
    );

    vector_pack #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_data(in_data), .in_last(in_last), .fill_mode(fill_mode),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
        .out_count(out_count_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference: place n beats in order, then paint every unused bit with the fill bit.
    function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] b [RATIO], input int n,
                                               input logic [1:0] fm, input bit msb);
        logic [OUT_W-1:0] v;
        logic fb;
        v = '0;
        for (int k = 0; k < n; k++) begin
            if (msb) v = v | (OUT_W'(b[k]) << (OUT_W - IN_W * (k + 1)));
            else     v = v | (OUT_W'(b[k]) << (IN_W * k));
        end
        case (fm)
            2'b01:   fb = 1'b1;
            2'b10:   fb = b[n-1][IN_W-1];
`ifdef VECTOR_PACK_XFILL_EN
            2'b11:   fb = 1'bx;
`endif
            default: fb = 1'b0;
        endcase
        for (int i = 0; i < OUT_W; i++) begin
            if (msb ? (i < OUT_W - IN_W * n) : (i >= IN_W * n)) v[i] = fb;
        end
        return v;
    endfunction

    // Random consumer back-pressure during the random test.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard: every handshake on either output must match the next prediction.
    always @(negedge clk) begin
        logic [OUT_W-1:0] ed;
        logic [2:0]       ec;
        if (rst_n === 1'b1 && out_ready === 1'b1 && out_valid_m === 1'b1) begin
            checks++;
            if (exp_m.size() == 0 || exp_l.size() == 0) begin
                errors++;
                $display("FAIL unexpected_vector: got m=%h l=%h with nothing predicted", out_data_m, out_data_l);
            end else begin
                ec = expc.pop_front();
                ed = exp_m.pop_front();
                if (out_data_m !== ed || out_count_m !== ec) begin
                    errors++;
                    $display("FAIL msb_vector: got %h/%0d, expected %h/%0d", out_data_m, out_count_m, ed, ec);
                end
                ed = exp_l.pop_front();
                if (out_valid_l !== 1'b1 || out_data_l !== ed || out_count_l !== ec) begin
                    errors++;
                    $display("FAIL lsb_vector: got v=%b %h/%0d, expected %h/%0d", out_valid_l, out_data_l, out_count_l, ed, ec);
                end
            end
        end
    end

    task automatic send_beat(input logic [IN_W-1:0] d, input logic last, input logic [1:0] fm);
        bit ok;
        ok        = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        fill_mode = fm;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            ok = (in_ready_m === 1'b1 && in_ready_l === 1'b1);
            @(posedge clk);
        end
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = IN_W'($urandom);
        fill_mode = 2'($urandom);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready never high for beat %h", d);
        end
    endtask

    task automatic send_vector(input logic [IN_W-1:0] b [RATIO], input int n,
                               input logic [1:0] fm, input bit gaps);
        logic last;
        exp_m.push_back(model(b, n, fm, 1'b1));
        exp_l.push_back(model(b, n, fm, 1'b0));
        expc.push_back(3'(n));
        for (int k = 0; k < n; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (k == n - 1) last = (n < RATIO) ? 1'b1 : 1'($urandom_range(0, 1));
            else            last = 1'b0;
            send_beat(b[k], last, (k == n - 1) ? fm : 2'($urandom));
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200 && exp_m.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (exp_m.size() != 0 || exp_l.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d vectors still pending", exp_m.size());
            exp_m.delete(); exp_l.delete(); expc.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        fill_mode = 2'b00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid_m !== 1'b0 || out_data_m !== '0 || out_count_m !== '0 ||
            out_valid_l !== 1'b0 || out_data_l !== '0 || out_count_l !== '0) begin
            errors++;
            $display("FAIL reset_state: v=%b d=%h c=%0d, expected 0/0000/0", out_valid_m, out_data_m, out_count_m);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready_m !== 1'b1 || in_ready_l !== 1'b1 || out_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, expected 1/0", in_ready_m, out_valid_m);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full();
        logic [IN_W-1:0] b [RATIO];
        b = '{4'h3, 4'h3, 4'h3, 4'h3};
        send_vector(b, 4, 2'($urandom), 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid_m !== 1'b1) begin
            errors++;
            $display("FAIL full_latency: out_valid=%b one cycle after last beat, expected 1", out_valid_m);
        end
        @(posedge clk); #1;
        b = '{4'h1, 4'h2, 4'h3, 4'h4};
        send_vector(b, 4, 2'($urandom), 1'b1);
        wait_drain();
    endtask

    task automatic test_early();
        logic [IN_W-1:0] b [RATIO];
        b = '{4'he, 4'he, 4'h0, 4'h0};
        send_vector(b, 2, 2'b00, 1'b0);
        b = '{4'h9, 4'h0, 4'h0, 4'h0};
        send_vector(b, 1, 2'b10, 1'b0);
        b = '{4'h7, 4'h0, 4'h0, 4'h0};
        send_vector(b, 1, 2'b11, 1'b0);
        b = '{4'h5, 4'hc, 4'h2, 4'h0};
        send_vector(b, 3, 2'b01, 1'b1);
        b = '{4'h3, 4'h0, 4'h0, 4'h0};
        send_vector(b, 1, 2'b10, 1'b1);
        wait_drain();
        @(negedge clk);
        checks++;
        if (out_valid_m !== 1'b0 || out_valid_l !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop: out_valid=%b after drain, expected 0", out_valid_m);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [IN_W-1:0] b [RATIO];
        logic [OUT_W-1:0] first_m, first_l;
        out_ready = 1'b0;
        b = '{IN_W'($urandom), IN_W'($urandom), IN_W'($urandom), IN_W'($urandom)};
        send_vector(b, 4, 2'b00, 1'b0);
        first_m = exp_m[0];
        first_l = exp_l[0];
        b = '{4'h5, 4'h0, 4'h0, 4'h0};
        exp_m.push_back(model(b, 1, 2'b01, 1'b1));
        exp_l.push_back(model(b, 1, 2'b01, 1'b0));
        expc.push_back(3'd1);
        in_valid = 1'b1; in_data = 4'h5; in_last = 1'b1; fill_mode = 2'b01;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready_m !== 1'b0 || out_valid_m !== 1'b1 || out_data_m !== first_m ||
                out_data_l !== first_l || out_count_m !== 3'd4) begin
                errors++;
                $display("FAIL stall_hold: in_ready=%b v=%b d=%h/%h c=%0d, expected 0 1 %h/%h 4",
                         in_ready_m, out_valid_m, out_data_m, out_data_l, out_count_m, first_m, first_l);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready_m !== 1'b1 || in_ready_l !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: in_ready=%b, expected 1", in_ready_m);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid_m !== 1'b1) begin
            errors++;
            $display("FAIL drain_and_load: out_valid=%b after simultaneous drain+completion, expected 1", out_valid_m);
        end
        @(posedge clk); #1;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        logic [IN_W-1:0] b [RATIO];
        out_ready = 1'b1;
        send_beat(4'h5, 1'b0, 2'b01);
        send_beat(4'h6, 1'b0, 2'b01);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1 || out_count_m !== '0 || out_data_m !== '0) begin
            errors++;
            $display("FAIL reset_mid: v=%b rdy=%b c=%0d d=%h, expected 0 1 0 0000", out_valid_m, in_ready_m, out_count_m, out_data_m);
        end
        @(posedge clk); #1;
        b = '{4'ha, 4'hb, 4'hc, 4'hd};
        send_vector(b, 4, 2'($urandom), 1'b0);
        wait_drain();
    endtask

    task automatic test_random();
        logic [IN_W-1:0] b [RATIO];
        rand_ready = 1;
        for (int v = 0; v < 40; v++) begin
            for (int k = 0; k < RATIO; k++) b[k] = IN_W'($urandom);
            send_vector(b, $urandom_range(1, RATIO), 2'($urandom), 1'b1);
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_full();
        test_early();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
